// File: rtl/hier_pkg.sv
// Shared defaults and constants for the folded-MSB hierarchical adder.
package hier_pkg;

    localparam int unsigned DEF_WIDTH = 2;
    localparam int unsigned DEF_CNT_W = 8;

    // Carry-event counter holds here instead of wrapping.
    localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;

endpackage

// File: rtl/hier_if.sv
// Signal bundle for driving and observing one hier adder instance.
interface hier_if
    import hier_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b, cin,
        input  sum, cout, sum_q, cout_q, carry_cnt
    );

    modport slave (
        input  a, b, cin,
        output sum, cout, sum_q, cout_q, carry_cnt
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell used as the ripple stage of hier.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule

// File: rtl/hier.sv
// Ripple-carry adder whose MSB is folded with the carry-out, plus a registered
// copy of the result and a saturating count of carry-out cycles.
module hier
    import hier_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    input  logic             clk,
    input  logic             reset,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CntSat = '1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_raw;
    logic [CNT_W-1:0] carry_cnt_q;
    logic [CNT_W-1:0] carry_cnt_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (s_raw[i]),
            .co  (carry[i+1])
        );
    end

    // Top bit carries the overflow information instead of discarding it.
    assign sum  = {s_raw[WIDTH-1] ^ carry[WIDTH], s_raw[WIDTH-2:0]};
    assign cout = carry[WIDTH];

    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if (cout && (carry_cnt_q != CntSat)) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            carry_cnt_q <= '0;
        end else begin
            sum_q       <= sum;
            cout_q      <= cout;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_hier.sv
// Directed self-checking bench for hier: combinational fold, registers,
// saturating counter, asynchronous reset and an exhaustive sweep.
module tb_hier;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    hier_if #(.WIDTH(2), .CNT_W(8)) bus ();

    hier #(.WIDTH(2), .CNT_W(8)) dut (
        .a         (bus.a),
        .b         (bus.b),
        .cin       (bus.cin),
        .sum       (bus.sum),
        .clk       (clk),
        .reset     (reset),
        .cout      (bus.cout),
        .sum_q     (bus.sum_q),
        .cout_q    (bus.cout_q),
        .carry_cnt (bus.carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] av, input logic [1:0] bv, input logic cv);
        bus.a   = av;
        bus.b   = bv;
        bus.cin = cv;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Inputs produce cout=1 while reset is held: registers and counter stay 0.
        drive(2'b11, 2'b11, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.sum_q !== 2'b00) $display("FAIL reset_sum_q got %b want 00", bus.sum_q);
        else passed++;
        total++;
        if (bus.cout_q !== 1'b0) $display("FAIL reset_cout_q got %b want 0", bus.cout_q);
        else passed++;
        total++;
        if (bus.carry_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", bus.carry_cnt);
        else passed++;
        total++;
        if (bus.sum !== 2'b01) $display("FAIL reset_comb_sum got %b want 01", bus.sum);
        else passed++;
        drive(2'b00, 2'b00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.sum, bus.cout} !== 3'b000) $display("FAIL vec_000 got %b want 000", {bus.sum, bus.cout});
        else passed++;
        @(negedge clk);
        total++;
        if (bus.sum_q !== 2'b00) $display("FAIL vec_000_q got %b want 00", bus.sum_q);
        else passed++;

        @(posedge clk); #1;
        drive(2'b10, 2'b01, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.sum, bus.cout} !== 3'b110) $display("FAIL vec_10_01 got %b want 110", {bus.sum, bus.cout});
        else passed++;

        @(posedge clk); #1;
        drive(2'b11, 2'b01, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.sum, bus.cout} !== 3'b101) $display("FAIL vec_11_01 got %b want 101", {bus.sum, bus.cout});
        else passed++;

        @(posedge clk); #1;
        drive(2'b01, 2'b10, 1'b1);
        @(negedge clk);
        total++;
        if ({bus.sum, bus.cout} !== 3'b101) $display("FAIL vec_01_10_c got %b want 101", {bus.sum, bus.cout});
        else passed++;
    endtask

    task automatic test_register();
        pulse_reset();
        drive(2'b11, 2'b11, 1'b1);
        #1;
        total++;
        if ({bus.sum, bus.cout} !== 3'b011) $display("FAIL reg_comb got %b want 011", {bus.sum, bus.cout});
        else passed++;
        @(negedge clk);
        total++;
        if (bus.sum_q !== 2'b01 || bus.cout_q !== 1'b1)
            $display("FAIL reg_capture got %b%b want 011", bus.sum_q, bus.cout_q);
        else passed++;
        total++;
        if (bus.carry_cnt !== 8'd1) $display("FAIL reg_cnt got %0d want 1", bus.carry_cnt);
        else passed++;
    endtask

    task automatic test_saturation();
        pulse_reset();
        drive(2'b11, 2'b11, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.carry_cnt !== 8'd10) $display("FAIL sat_cnt10 got %0d want 10", bus.carry_cnt);
        else passed++;
        repeat (290) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.carry_cnt !== 8'd255) $display("FAIL sat_cnt300 got %0d want 255", bus.carry_cnt);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.carry_cnt !== 8'd255) $display("FAIL sat_hold got %0d want 255", bus.carry_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        total++;
        if (bus.sum_q !== 2'b00 || bus.cout_q !== 1'b0 || bus.carry_cnt !== 8'd0)
            $display("FAIL mid_async got %b %b %0d want 00 0 0", bus.sum_q, bus.cout_q,
                     bus.carry_cnt);
        else passed++;
        drive(2'b10, 2'b01, 1'b0);
        #1;
        total++;
        if ({bus.sum, bus.cout} !== 3'b110) $display("FAIL mid_comb got %b want 110", {bus.sum, bus.cout});
        else passed++;
        drive(2'b11, 2'b01, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.carry_cnt !== 8'd0) $display("FAIL mid_hold got %0d want 0", bus.carry_cnt);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.carry_cnt !== 8'd1 || bus.sum_q !== 2'b10 || bus.cout_q !== 1'b1)
            $display("FAIL mid_restart got cnt %0d q %b%b want cnt 1 q 101", bus.carry_cnt,
                     bus.sum_q, bus.cout_q);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [2:0] t;
        logic [1:0] exp_sum;
        logic [1:0] prev_sum;
        logic       exp_cout;
        logic       prev_cout;
        logic [4:0] v;
        prev_sum  = 2'b00;
        prev_cout = 1'b0;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            @(posedge clk); #1;
            drive(v[4:3], v[2:1], v[0]);
            t        = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
            exp_sum  = {t[1] ^ t[2], t[0]};
            exp_cout = t[2];
            @(negedge clk);
            total++;
            if (bus.sum !== exp_sum || bus.cout !== exp_cout)
                $display("FAIL sweep_%0d got %b%b want %b%b", i, bus.sum, bus.cout, exp_sum,
                         exp_cout);
            else passed++;
            if (i > 0) begin
                total++;
                if (bus.sum_q !== prev_sum || bus.cout_q !== prev_cout)
                    $display("FAIL sweep_q_%0d got %b%b want %b%b", i, bus.sum_q, bus.cout_q,
                             prev_sum, prev_cout);
                else passed++;
            end
            prev_sum  = exp_sum;
            prev_cout = exp_cout;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        test_reset();
        test_vectors();
        test_register();
        test_saturation();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
